// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: operand/response records and FSM states.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int RES_W = 64;

    typedef logic [2:0] alu_op_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        alu_op_t          op;
    } alu_cmd_t;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic             ov;
        alu_op_t          op;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_stat_counters.sv
// Completion statistics: op count wraps, overflow count saturates at all-ones.
module alu_stat_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             ov_i,
    output logic [CNT_W-1:0] op_count_o,
    output logic [CNT_W-1:0] ov_count_o
);

    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] ov_cnt_q, ov_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        ov_cnt_d = ov_cnt_q;
        if (en_i) begin
            op_cnt_d = op_cnt_q + CNT_W'(1);
            if (ov_i && (ov_cnt_q != '1))
                ov_cnt_d = ov_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
            ov_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
            ov_cnt_q <= ov_cnt_d;
        end
    end

    assign op_count_o = op_cnt_q;
    assign ov_count_o = ov_cnt_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for a combinational ALU: holds operands stable, waits a fixed
// settle time, then captures the result into a valid/ready response slot.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [63:0]      alu_res,
    input  logic             alu_ov,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_res,
    output logic             rsp_ov,
    output logic [2:0]       rsp_op,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ov_count
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    issue_state_t state_q;
    logic [3:0]   cnt_q;
    alu_cmd_t     cmd_q;
    alu_rsp_t     rsp_q;
    logic         rsp_valid_q;
    logic         accept;
    logic         rsp_hs;

    // A new command may enter on the same edge the pending response leaves.
    assign cmd_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_hs    = rsp_valid_q & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= '{a: cmd_a, b: cmd_b, op: cmd_op};
                cnt_q <= SETTLE_INIT;
            end
            case (state_q)
                IDLE: begin
                    if (accept)
                        state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        rsp_q       <= '{res: alu_res, ov: alu_ov, op: cmd_q.op};
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? SETTLE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    alu_stat_counters #(.CNT_W(CNT_W)) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (rsp_hs),
        .ov_i       (rsp_q.ov),
        .op_count_o (op_count),
        .ov_count_o (ov_count)
    );

    assign alu_a      = cmd_q.a;
    assign alu_b      = cmd_q.b;
    assign alu_opcode = cmd_q.op;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = rsp_q.res;
    assign rsp_ov     = rsp_q.ov;
    assign rsp_op     = rsp_q.op;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench: two stages (settle 1 / 4-bit counters, settle 3 / 16-bit
// counters) sharing operand and reset stimulus, each with a concat-style ALU stub.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid1, cmd_valid3;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_ready;

    logic        cmd_ready1, rsp_valid1, rsp_ov1, busy1, alu_ov1;
    logic [31:0] alu_a1, alu_b1;
    logic [2:0]  alu_opcode1, rsp_op1;
    logic [63:0] alu_res1, rsp_res1;
    logic [3:0]  op_count1, ov_count1;

    logic        cmd_ready3, rsp_valid3, rsp_ov3, busy3, alu_ov3;
    logic [31:0] alu_a3, alu_b3;
    logic [2:0]  alu_opcode3, rsp_op3;
    logic [63:0] alu_res3, rsp_res3;
    logic [15:0] op_count3, ov_count3;

    int errors = 0;
    int checks = 0;

    assign alu_res1 = {alu_a1, alu_b1};
    assign alu_ov1  = alu_a1[31];
    assign alu_res3 = {alu_a3, alu_b3};
    assign alu_ov3  = alu_a3[31];

    alu_issue_stage #(.SETTLE_CYCLES(1), .CNT_W(4)) u_s1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1),
        .alu_res(alu_res1), .alu_ov(alu_ov1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_res(rsp_res1),
        .rsp_ov(rsp_ov1), .rsp_op(rsp_op1), .busy(busy1),
        .op_count(op_count1), .ov_count(ov_count1)
    );

    alu_issue_stage #(.SETTLE_CYCLES(3), .CNT_W(16)) u_s3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
        .alu_res(alu_res3), .alu_ov(alu_ov3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_res(rsp_res3),
        .rsp_ov(rsp_ov3), .rsp_op(rsp_op3), .busy(busy3),
        .op_count(op_count3), .ov_count(ov_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({alu_a1, alu_b1, alu_opcode1} !== 67'd0) begin
            errors++; $display("FAIL reset_alu: got %h exp 0", {alu_a1, alu_b1, alu_opcode1});
        end
        checks++;
        if ({rsp_valid1, rsp_res1, rsp_ov1, rsp_op1, busy1} !== 70'd0) begin
            errors++; $display("FAIL reset_rsp: got %h exp 0", {rsp_valid1, rsp_res1, rsp_ov1, rsp_op1, busy1});
        end
        checks++;
        if ({op_count1, ov_count1, op_count3, ov_count3} !== 40'd0) begin
            errors++; $display("FAIL reset_cnt: got %h exp 0", {op_count1, ov_count1, op_count3, ov_count3});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready1, cmd_ready3} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b exp 11", {cmd_ready1, cmd_ready3});
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        cmd_a = 32'hA5A5_A5A5; cmd_b = 32'h5A5A_5A5A; cmd_op = 3'd0;
        cmd_valid1 = 1'b1;
        tick();
        cmd_valid1 = 1'b0;
        checks++;
        if ({rsp_valid1, busy1, alu_a1} !== {1'b0, 1'b1, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL single_launch: got %h exp %h", {rsp_valid1, busy1, alu_a1}, {1'b0, 1'b1, 32'hA5A5_A5A5});
        end
        tick();
        checks++;
        if ({rsp_valid1, rsp_res1, rsp_ov1, rsp_op1} !== {1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 3'd0}) begin
            errors++; $display("FAIL single_rsp: got %h exp %h", {rsp_valid1, rsp_res1, rsp_ov1, rsp_op1}, {1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 3'd0});
        end
        tick();
        checks++;
        if ({rsp_valid1, busy1, op_count1, ov_count1, rsp_res1} !== {2'b00, 4'd1, 4'd1, 64'hA5A5_A5A5_5A5A_5A5A}) begin
            errors++; $display("FAIL single_done: got %h exp %h", {rsp_valid1, busy1, op_count1, ov_count1, rsp_res1}, {2'b00, 4'd1, 4'd1, 64'hA5A5_A5A5_5A5A_5A5A});
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        cmd_a = 32'h1111_1111; cmd_b = 32'h2222_2222; cmd_op = 3'd3;
        cmd_valid1 = 1'b1;
        tick();
        cmd_a = 32'h8000_0000; cmd_b = 32'h0000_0033; cmd_op = 3'd5;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid1, cmd_ready1, rsp_res1, rsp_op1} !== {2'b10, 64'h1111_1111_2222_2222, 3'd3}) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h exp %h", i, {rsp_valid1, cmd_ready1, rsp_res1, rsp_op1}, {2'b10, 64'h1111_1111_2222_2222, 3'd3});
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready1 !== 1'b1) begin
            errors++; $display("FAIL bp_ready: got %b exp 1", cmd_ready1);
        end
        tick();
        cmd_valid1 = 1'b0;
        checks++;
        if ({rsp_valid1, busy1, alu_a1, op_count1, ov_count1} !== {2'b01, 32'h8000_0000, 4'd2, 4'd1}) begin
            errors++; $display("FAIL bp_same_edge: got %h exp %h", {rsp_valid1, busy1, alu_a1, op_count1, ov_count1}, {2'b01, 32'h8000_0000, 4'd2, 4'd1});
        end
        tick();
        checks++;
        if ({rsp_valid1, rsp_res1, rsp_ov1, rsp_op1} !== {1'b1, 64'h8000_0000_0000_0033, 1'b1, 3'd5}) begin
            errors++; $display("FAIL bp_second_rsp: got %h exp %h", {rsp_valid1, rsp_res1, rsp_ov1, rsp_op1}, {1'b1, 64'h8000_0000_0000_0033, 1'b1, 3'd5});
        end
        tick();
        checks++;
        if ({rsp_valid1, op_count1, ov_count1} !== {1'b0, 4'd3, 4'd2}) begin
            errors++; $display("FAIL bp_counts: got %h exp %h", {rsp_valid1, op_count1, ov_count1}, {1'b0, 4'd3, 4'd2});
        end
    endtask

    task automatic test_sweep();
        logic [2:0] opv;
        do_reset();
        rsp_ready = 1'b1;
        cmd_a = 32'h1234_5678; cmd_b = 32'h0;
        for (int i = 0; i < 8; i++) begin
            opv = 3'(i);
            cmd_op = opv;
            cmd_valid3 = 1'b1;
            tick();
            cmd_valid3 = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rsp_valid3 !== 1'b0) begin
                    errors++; $display("FAIL sweep_early[%0d.%0d]: got %b exp 0", i, k, rsp_valid3);
                end
                if (k < 2) tick();
                else tick();
            end
            checks++;
            if ({rsp_valid3, rsp_res3, rsp_ov3, rsp_op3} !== {1'b1, 64'h1234_5678_0000_0000, 1'b0, opv}) begin
                errors++; $display("FAIL sweep_rsp[%0d]: got %h exp %h", i, {rsp_valid3, rsp_res3, rsp_ov3, rsp_op3}, {1'b1, 64'h1234_5678_0000_0000, 1'b0, opv});
            end
            tick();
        end
        checks++;
        if ({op_count3, ov_count3} !== {16'd8, 16'd0}) begin
            errors++; $display("FAIL sweep_counts: got %h exp %h", {op_count3, ov_count3}, {16'd8, 16'd0});
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h1; cmd_op = 3'd2;
        cmd_valid3 = 1'b1;
        tick();
        cmd_valid3 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a3, alu_b3, alu_opcode3, rsp_valid3, rsp_res3, rsp_ov3, rsp_op3, busy3, op_count3, ov_count3} !== 169'd0) begin
            errors++; $display("FAIL midrst_zero: got %h exp 0", {alu_a3, alu_b3, alu_opcode3, rsp_valid3, rsp_res3, busy3, op_count3});
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready3 !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b exp 1", cmd_ready3);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid3 !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midrst_no_rsp: got %0d responses exp 0", seen);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            cmd_a = 32'h8000_0000 + 32'(i); cmd_b = 32'(i); cmd_op = 3'd1;
            cmd_valid1 = 1'b1;
            tick();
            cmd_valid1 = 1'b0;
            tick();
            tick();
            if (i == 15) begin
                checks++;
                if ({op_count1, ov_count1} !== 8'hFF) begin
                    errors++; $display("FAIL sat_15: got %h exp ff", {op_count1, ov_count1});
                end
            end
            if (i == 16) begin
                checks++;
                if ({op_count1, ov_count1} !== 8'h0F) begin
                    errors++; $display("FAIL sat_16: got %h exp 0f", {op_count1, ov_count1});
                end
            end
        end
        checks++;
        if ({op_count1, ov_count1} !== 8'h1F) begin
            errors++; $display("FAIL sat_17: got %h exp 1f", {op_count1, ov_count1});
        end
    endtask

    task automatic test_idle_hold();
        cmd_a = 32'h0BAD_F00D; cmd_b = 32'hFFFF_FFFF; cmd_op = 3'd7;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({alu_a1, alu_b1, alu_opcode1, busy1, rsp_res1} !== {32'h8000_0011, 32'h0000_0011, 3'd1, 1'b0, 64'h8000_0011_0000_0011}) begin
                errors++; $display("FAIL idle_hold[%0d]: got %h exp %h", i, {alu_a1, alu_b1, alu_opcode1, busy1, rsp_res1}, {32'h8000_0011, 32'h0000_0011, 3'd1, 1'b0, 64'h8000_0011_0000_0011});
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rsp_ready = 1'b0;
        #3;
        test_reset();
        test_single();
        test_backpressure();
        test_sweep();
        test_reset_mid();
        test_saturation();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
